ahb_sram_arbiter: RTL and testbench
===================================

// Module: ahb_sram_arbiter
// PURPOSE
//  Two-master AHB-Lite arbiter in front of the single AHB SRAM slave port.
//  It shares the SRAM between two masters, e.g. the core instruction port (m0) and the data port (m1).
//  - Uncontended transfers pass straight through with zero added latency.
//  - On a conflict, the losing address phase is captured in a hold stage and that master is stalled.
//  - The held transfer is replayed to the slave on the next free slave cycle.
// PARAMETERS
//  AW  32  address width; equals `HADDR_BUS_WIDTH
//  DW  32  data width; matches `HDATA_BUS
// PORTS
//  hclk            in   1   AHB clock
//  hresetn         in   1   async reset, active-low
//  mN_hsel         in   1   master N select (N = 0, 1; same list per master)
//  mN_hwrite       in   1   master N write
//  mN_hready       in   1   master N bus hready (address-phase qualifier)
//  mN_hsize        in   3   master N size
//  mN_hburst       in   3   master N burst; SINGLE only
//  mN_htrans       in   2   master N trans
//  mN_haddr        in   AW  master N address
//  mN_hwdata       in   DW  master N write data
//  mN_hreadyout    out  1   stall/complete to master N
//  mN_hresp        out  2   response to master N
//  mN_hrdata       out  DW  read data to master N
//  s_hsel          out  1   slave select
//  s_hwrite        out  1   slave write
//  s_hready        out  1   slave hready_i
//  s_hsize         out  3   slave size
//  s_hburst        out  3   slave burst
//  s_htrans        out  2   slave trans
//  s_haddr         out  AW  slave address
//  s_hwdata        out  DW  slave write data
//  s_hreadyout     in   1   slave ready
//  s_hresp         in   2   slave resp
//  s_hrdata        in   DW  slave read data
// BEHAVIOUR
//  - Requests:
//    - live_N = mN_hsel & mN_hready & mN_htrans[1] & !pend_N.
//    - req_N = live_N | pend_N.
//  - Grant:
//    - Evaluated combinationally, only when s_hreadyout = 1.
//    - A pending (held) request always beats a live request.
//    - Among equals (both live or both pending), winner = priority rule (see CONFIGURATION).
//  - Slave address phase:
//    - Drives the granted source: the hold register if pend, else the live master inputs.
//    - s_hsel = |req, s_hready = s_hreadyout.
//    - No grant -> s_htrans = IDLE, s_hsel = 0.
//  - Loser: a live loser, or any live request while s_hreadyout = 0, is captured into hold_N at the clock edge; pend_N <= 1.
//  - Pend clear: pend_N clears at the edge where its held transfer is granted (s_hreadyout = 1).
//  - Data phase, updated when s_hreadyout = 1:
//    - dv <= granted; own <= grant index.
//    - s_hwdata = m[own]_hwdata.
//  - Master outputs:
//    - mN_hreadyout = pend_N ? 0 : (dv & own==N) ? s_hreadyout : 1.
//    - mN_hresp = (dv & own==N) ? s_hresp : OKAY.
//    - mN_hrdata = s_hrdata.
//  - Latency: uncontended = 0 cycles added; loser = +1 cycle per transfer queued ahead of it.
//  - Slave held off (s_hreadyout = 0): grant, hold registers, dv and own are frozen; pending requests persist.
//  - Reset (async, also mid-transfer):
//    - pend, dv, own and rr clear to 0; held transfers are dropped.
//    - mN_hreadyout = 1, mN_hresp = 00, s_htrans = IDLE, s_hsel = 0.
// CONFIGURATION
//  SRAM_ARB_RR_EN defined:
//    - Tie winner = rr pointer; rr flips to the non-winner after each tie.
//    - rr resets to 0.
//  SRAM_ARB_RR_EN undefined:
//    - Fixed priority, m0 wins ties.
//    - Pend-first rule still prevents starvation.
// STRUCTURE
//  Shared defines in core/defines.v:
//    - HTRANS_IDLE/NONSEQ, HBURST_SINGLE and HRESP_OKAY constants.
//    - The AW/DW width macros.
//  Sub-module ahb_arb_hold, instantiated per master:
//    - Capture register for write/size/burst/trans/addr plus the pend flag.
//    - Output mux live/held.
//  The top level holds the grant logic, the rr pointer and the data-phase owner registers.
// TESTING
//  1. m0 WRITE NONSEQ 0x0000_0010, 0xA5A5A5A5; m1 idle
//     -> s_haddr = 0x10 in the same cycle; m0_hreadyout = 1;
//     -> s_hwdata = 0xA5A5A5A5 in the next cycle.
//  2. Cycle t: m0 READ 0x20, m1 WRITE 0x8004
//     -> t: s_haddr = 0x20;
//     -> t+1: s_haddr = 0x8004, m1_hreadyout = 0, m0 gets its data;
//     -> t+2: m1_hreadyout = 1.
//  3. Test 2 plus m0 issues a new READ 0x24 at t+1
//     -> held 0x8004 goes first; 0x24 is held and goes at t+2;
//     -> m0_hreadyout = 0 at t+2.
//  4. s_hreadyout forced 0 for 2 cycles while both masters request
//     -> s_haddr, pend and own stable;
//     -> both masters complete in grant order once ready returns.
//  5. Three consecutive tie cycles (both live at once) with SRAM_ARB_RR_EN
//     -> tie winners m0, m1, m0;
//     -> without the macro: m0 every time.
//  6. hresetn pulsed low while pend_1 = 1
//     -> immediately m1_hreadyout = 1 and s_htrans = IDLE;
//     -> after release: no replay of the dropped transfer.

Source files
------------

// File: rtl/ahb_sram_arbiter_pkg.sv
// Shared AHB constants and grant helpers for the two-master SRAM arbiter.
package ahb_sram_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_M0   = 2'b01,
        GRANT_M1   = 2'b10
    } grant_t;

    // Picks between two requests of equal class; prefer_m1 settles a tie.
    function automatic grant_t pick_grant(input logic req0, input logic req1,
                                          input logic prefer_m1);
        if (req0 && req1)
            return prefer_m1 ? GRANT_M1 : GRANT_M0;
        else if (req0)
            return GRANT_M0;
        else if (req1)
            return GRANT_M1;
        else
            return GRANT_NONE;
    endfunction

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-master hold stage: captures a losing address phase and muxes held/live
// control toward the slave.
module ahb_arb_hold
    import ahb_sram_arbiter_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          capture,
    input  logic          grant_done,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [1:0]    htrans,
    input  logic [AW-1:0] haddr,
    output logic          pend,
    output logic          src_hwrite,
    output logic [2:0]    src_hsize,
    output logic [2:0]    src_hburst,
    output logic [1:0]    src_htrans,
    output logic [AW-1:0] src_haddr
);

    logic          held_hwrite;
    logic [2:0]    held_hsize;
    logic [2:0]    held_hburst;
    logic [1:0]    held_htrans;
    logic [AW-1:0] held_haddr;

    // Capture only happens for a live request, so it never coincides with a release.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend        <= 1'b0;
            held_hwrite <= 1'b0;
            held_hsize  <= 3'b000;
            held_hburst <= HBURST_SINGLE;
            held_htrans <= HTRANS_IDLE;
            held_haddr  <= '0;
        end else if (capture) begin
            pend        <= 1'b1;
            held_hwrite <= hwrite;
            held_hsize  <= hsize;
            held_hburst <= hburst;
            held_htrans <= htrans;
            held_haddr  <= haddr;
        end else if (grant_done) begin
            pend        <= 1'b0;
        end
    end

    assign src_hwrite = pend ? held_hwrite : hwrite;
    assign src_hsize  = pend ? held_hsize  : hsize;
    assign src_hburst = pend ? held_hburst : hburst;
    assign src_htrans = pend ? held_htrans : htrans;
    assign src_haddr  = pend ? held_haddr  : haddr;

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Two-master AHB-Lite arbiter in front of one SRAM slave port.
// Define SRAM_ARB_RR_EN for round-robin tie breaking; default is m0-wins priority.
module ahb_sram_arbiter
    import ahb_sram_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          m0_hsel,
    input  logic          m0_hwrite,
    input  logic          m0_hready,
    input  logic [2:0]    m0_hsize,
    input  logic [2:0]    m0_hburst,
    input  logic [1:0]    m0_htrans,
    input  logic [AW-1:0] m0_haddr,
    input  logic [DW-1:0] m0_hwdata,
    output logic          m0_hreadyout,
    output logic [1:0]    m0_hresp,
    output logic [DW-1:0] m0_hrdata,
    input  logic          m1_hsel,
    input  logic          m1_hwrite,
    input  logic          m1_hready,
    input  logic [2:0]    m1_hsize,
    input  logic [2:0]    m1_hburst,
    input  logic [1:0]    m1_htrans,
    input  logic [AW-1:0] m1_haddr,
    input  logic [DW-1:0] m1_hwdata,
    output logic          m1_hreadyout,
    output logic [1:0]    m1_hresp,
    output logic [DW-1:0] m1_hrdata,
    output logic          s_hsel,
    output logic          s_hwrite,
    output logic          s_hready,
    output logic [2:0]    s_hsize,
    output logic [2:0]    s_hburst,
    output logic [1:0]    s_htrans,
    output logic [AW-1:0] s_haddr,
    output logic [DW-1:0] s_hwdata,
    input  logic          s_hreadyout,
    input  logic [1:0]    s_hresp,
    input  logic [DW-1:0] s_hrdata
);

    logic          pend0, pend1, live0, live1;
    logic          tie_pref, tie;
    grant_t        grant;
    logic          dv, own;
    logic          src0_hwrite, src1_hwrite;
    logic [2:0]    src0_hsize, src1_hsize, src0_hburst, src1_hburst;
    logic [1:0]    src0_htrans, src1_htrans;
    logic [AW-1:0] src0_haddr, src1_haddr;

    // Live requests are masked during reset so the slave sees no select while held in reset.
    assign live0 = hresetn & m0_hsel & m0_hready & m0_htrans[1] & ~pend0;
    assign live1 = hresetn & m1_hsel & m1_hready & m1_htrans[1] & ~pend1;

    assign grant = (pend0 | pend1) ? pick_grant(pend0, pend1, tie_pref)
                                   : pick_grant(live0, live1, tie_pref);
    assign tie   = (pend0 & pend1) | (~pend0 & ~pend1 & live0 & live1);

    ahb_arb_hold #(.AW(AW)) u_hold0 (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .capture    (live0 & (~s_hreadyout | (grant != GRANT_M0))),
        .grant_done (pend0 & s_hreadyout & (grant == GRANT_M0)),
        .hwrite     (m0_hwrite),
        .hsize      (m0_hsize),
        .hburst     (m0_hburst),
        .htrans     (m0_htrans),
        .haddr      (m0_haddr),
        .pend       (pend0),
        .src_hwrite (src0_hwrite),
        .src_hsize  (src0_hsize),
        .src_hburst (src0_hburst),
        .src_htrans (src0_htrans),
        .src_haddr  (src0_haddr)
    );

    ahb_arb_hold #(.AW(AW)) u_hold1 (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .capture    (live1 & (~s_hreadyout | (grant != GRANT_M1))),
        .grant_done (pend1 & s_hreadyout & (grant == GRANT_M1)),
        .hwrite     (m1_hwrite),
        .hsize      (m1_hsize),
        .hburst     (m1_hburst),
        .htrans     (m1_htrans),
        .haddr      (m1_haddr),
        .pend       (pend1),
        .src_hwrite (src1_hwrite),
        .src_hsize  (src1_hsize),
        .src_hburst (src1_hburst),
        .src_htrans (src1_htrans),
        .src_haddr  (src1_haddr)
    );

`ifdef SRAM_ARB_RR_EN
    logic rr;

    // The pointer moves to the tie loser, so the next tie goes the other way.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            rr <= 1'b0;
        else if (s_hreadyout && tie)
            rr <= (grant != GRANT_M1);
    end

    assign tie_pref = rr;
`else
    assign tie_pref = 1'b0;
`endif

    // The data-phase owner only advances when the slave accepts an address phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dv  <= 1'b0;
            own <= 1'b0;
        end else if (s_hreadyout) begin
            dv  <= (grant != GRANT_NONE);
            own <= (grant == GRANT_M1);
        end
    end

    assign s_hsel   = live0 | live1 | pend0 | pend1;
    assign s_hready = s_hreadyout;
    assign s_hwrite = (grant == GRANT_M1) ? src1_hwrite : src0_hwrite;
    assign s_hsize  = (grant == GRANT_M1) ? src1_hsize  : src0_hsize;
    assign s_hburst = (grant == GRANT_M1) ? src1_hburst : src0_hburst;
    assign s_haddr  = (grant == GRANT_M1) ? src1_haddr  : src0_haddr;
    assign s_htrans = (grant == GRANT_M1) ? src1_htrans :
                      (grant == GRANT_M0) ? src0_htrans : HTRANS_IDLE;
    assign s_hwdata = own ? m1_hwdata : m0_hwdata;

    assign m0_hreadyout = pend0 ? 1'b0 : (dv & ~own) ? s_hreadyout : 1'b1;
    assign m1_hreadyout = pend1 ? 1'b0 : (dv &  own) ? s_hreadyout : 1'b1;
    assign m0_hresp     = (dv & ~own) ? s_hresp : HRESP_OKAY;
    assign m1_hresp     = (dv &  own) ? s_hresp : HRESP_OKAY;
    assign m0_hrdata    = s_hrdata;
    assign m1_hrdata    = s_hrdata;

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Directed self-checking bench for ahb_sram_arbiter; honours SRAM_ARB_RR_EN for tie expectations.
module tb_ahb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        m0_hsel, m0_hwrite, m1_hsel, m1_hwrite;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic        m0_hready, m1_hready, m0_hreadyout, m1_hreadyout;
    logic [1:0]  m0_hresp, m1_hresp;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        s_hsel, s_hwrite, s_hready;
    logic [2:0]  s_hsize, s_hburst;
    logic [1:0]  s_htrans;
    logic [31:0] s_haddr, s_hwdata;
    logic        slave_ready;
    logic [1:0]  slave_resp;
    logic [31:0] slave_rdata, slave_dp_addr;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 hclk = ~hclk;

    // Each master sees its own readyout as its bus hready, as in a single-master AHB-Lite segment.
    assign m0_hready = m0_hreadyout;
    assign m1_hready = m1_hreadyout;

    // Slave model returns the inverted data-phase address as read data.
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            slave_dp_addr <= 32'h0;
        else if (s_hready && s_hsel && s_htrans[1])
            slave_dp_addr <= s_haddr;
    end
    assign slave_rdata = ~slave_dp_addr;

    ahb_sram_arbiter dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_hsel(m0_hsel), .m0_hwrite(m0_hwrite), .m0_hready(m0_hready),
        .m0_hsize(3'b010), .m0_hburst(3'b000), .m0_htrans(m0_htrans),
        .m0_haddr(m0_haddr), .m0_hwdata(m0_hwdata), .m0_hreadyout(m0_hreadyout),
        .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
        .m1_hsel(m1_hsel), .m1_hwrite(m1_hwrite), .m1_hready(m1_hready),
        .m1_hsize(3'b010), .m1_hburst(3'b000), .m1_htrans(m1_htrans),
        .m1_haddr(m1_haddr), .m1_hwdata(m1_hwdata), .m1_hreadyout(m1_hreadyout),
        .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
        .s_hsel(s_hsel), .s_hwrite(s_hwrite), .s_hready(s_hready),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_htrans(s_htrans),
        .s_haddr(s_haddr), .s_hwdata(s_hwdata),
        .s_hreadyout(slave_ready), .s_hresp(slave_resp), .s_hrdata(slave_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic valid, input logic write,
                                 input logic [31:0] addr);
        if (m == 0) begin
            m0_hsel = valid; m0_hwrite = write; m0_haddr = addr;
            m0_htrans = valid ? 2'b10 : 2'b00;
        end else begin
            m1_hsel = valid; m1_hwrite = write; m1_haddr = addr;
            m1_htrans = valid ? 2'b10 : 2'b00;
        end
    endtask

    task automatic nextCycle;
        @(posedge hclk);
        #1;
    endtask

    task automatic resetDut;
        hresetn = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        slave_ready = 1'b1;
        slave_resp  = 2'b00;
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        m0_hwdata = 32'h0; m1_hwdata = 32'h1111_1111;
        resetDut();
        hresetn = 1'b0;
        #1;
        checkOutput("rst_m0_hreadyout", {31'b0, m0_hreadyout}, 32'h1);
        checkOutput("rst_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h1);
        checkOutput("rst_m0_hresp", {30'b0, m0_hresp}, 32'h0);
        checkOutput("rst_s_htrans", {30'b0, s_htrans}, 32'h0);
        checkOutput("rst_s_hsel", {31'b0, s_hsel}, 32'h0);
        resetDut();

        // Uncontended write passes through with zero latency.
        nextCycle();
        applyStimulus(0, 1'b1, 1'b1, 32'h10);
        @(negedge hclk);
        checkOutput("t1_s_haddr", s_haddr, 32'h10);
        checkOutput("t1_s_hwrite", {31'b0, s_hwrite}, 32'h1);
        checkOutput("t1_s_htrans", {30'b0, s_htrans}, 32'h2);
        checkOutput("t1_m0_hreadyout", {31'b0, m0_hreadyout}, 32'h1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        m0_hwdata = 32'hA5A5_A5A5;
        @(negedge hclk);
        checkOutput("t1_s_hwdata", s_hwdata, 32'hA5A5_A5A5);
        checkOutput("t1_idle_htrans", {30'b0, s_htrans}, 32'h0);

        // Conflict: m0 wins, m1 is held and replayed next cycle.
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h20);
        applyStimulus(1, 1'b1, 1'b1, 32'h8004);
        @(negedge hclk);
        checkOutput("t2_t_s_haddr", s_haddr, 32'h20);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        m1_hwdata = 32'hDEAD_BEEF;
        @(negedge hclk);
        checkOutput("t2_t1_s_haddr", s_haddr, 32'h8004);
        checkOutput("t2_t1_s_hwrite", {31'b0, s_hwrite}, 32'h1);
        checkOutput("t2_t1_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h0);
        checkOutput("t2_t1_m0_hreadyout", {31'b0, m0_hreadyout}, 32'h1);
        checkOutput("t2_t1_m0_hrdata", m0_hrdata, 32'hFFFF_FFDF);
        nextCycle();
        @(negedge hclk);
        checkOutput("t2_t2_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h1);
        checkOutput("t2_t2_s_hwdata", s_hwdata, 32'hDEAD_BEEF);
        checkOutput("t2_t2_s_htrans", {30'b0, s_htrans}, 32'h0);

        // Held transfer beats a new live request from the winner.
        resetDut();
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h20);
        applyStimulus(1, 1'b1, 1'b1, 32'h8004);
        @(negedge hclk);
        checkOutput("t3_t_s_haddr", s_haddr, 32'h20);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h24);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("t3_t1_s_haddr", s_haddr, 32'h8004);
        checkOutput("t3_t1_m0_hreadyout", {31'b0, m0_hreadyout}, 32'h1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("t3_t2_s_haddr", s_haddr, 32'h24);
        checkOutput("t3_t2_m0_hreadyout", {31'b0, m0_hreadyout}, 32'h0);
        checkOutput("t3_t2_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h1);
        nextCycle();
        @(negedge hclk);
        checkOutput("t3_t3_m0_hreadyout", {31'b0, m0_hreadyout}, 32'h1);
        checkOutput("t3_t3_m0_hrdata", m0_hrdata, 32'hFFFF_FFDB);

        // Slave wait states with both masters requesting.
        resetDut();
        nextCycle();
        slave_ready = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 32'h40);
        applyStimulus(1, 1'b1, 1'b0, 32'h44);
        @(negedge hclk);
        checkOutput("t4_w0_s_haddr", s_haddr, 32'h40);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("t4_w1_s_haddr", s_haddr, 32'h40);
        checkOutput("t4_w1_m0_hreadyout", {31'b0, m0_hreadyout}, 32'h0);
        checkOutput("t4_w1_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h0);
        nextCycle();
        slave_ready = 1'b1;
        @(negedge hclk);
        checkOutput("t4_r0_s_haddr", s_haddr, 32'h40);
        checkOutput("t4_r0_s_hsel", {31'b0, s_hsel}, 32'h1);
        nextCycle();
        @(negedge hclk);
        checkOutput("t4_r1_s_haddr", s_haddr, 32'h44);
        checkOutput("t4_r1_m0_hreadyout", {31'b0, m0_hreadyout}, 32'h1);
        checkOutput("t4_r1_m0_hrdata", m0_hrdata, 32'hFFFF_FFBF);
        checkOutput("t4_r1_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h0);
        nextCycle();
        slave_resp = 2'b01;
        @(negedge hclk);
        checkOutput("t4_r2_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h1);
        checkOutput("t4_r2_m1_hrdata", m1_hrdata, 32'hFFFF_FFBB);
        checkOutput("t4_r2_m1_hresp", {30'b0, m1_hresp}, 32'h1);
        checkOutput("t4_r2_m0_hresp", {30'b0, m0_hresp}, 32'h0);
        checkOutput("t4_r2_s_htrans", {30'b0, s_htrans}, 32'h0);
        slave_resp = 2'b00;

        // Three separate tie events.
        resetDut();
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h100);
        applyStimulus(1, 1'b1, 1'b0, 32'h104);
        @(negedge hclk);
        checkOutput("t5_tie1_winner", s_haddr, 32'h100);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("t5_tie1_loser", s_haddr, 32'h104);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h108);
        applyStimulus(1, 1'b1, 1'b0, 32'h10C);
        @(negedge hclk);
        checkOutput("t5_tie2_winner", s_haddr, RR_BUILD ? 32'h10C : 32'h108);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("t5_tie2_loser", s_haddr, RR_BUILD ? 32'h108 : 32'h10C);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h110);
        applyStimulus(1, 1'b1, 1'b0, 32'h114);
        @(negedge hclk);
        checkOutput("t5_tie3_winner", s_haddr, 32'h110);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("t5_tie3_loser", s_haddr, 32'h114);

        // Reset while m1 holds a transfer drops it.
        resetDut();
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h200);
        applyStimulus(1, 1'b1, 1'b0, 32'h204);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t6_pend_s_haddr", s_haddr, 32'h204);
        checkOutput("t6_pend_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h0);
        hresetn = 1'b0;
        #1;
        checkOutput("t6_rst_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h1);
        checkOutput("t6_rst_s_htrans", {30'b0, s_htrans}, 32'h0);
        checkOutput("t6_rst_s_hsel", {31'b0, s_hsel}, 32'h0);
        nextCycle();
        hresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            checkOutput("t6_noreplay_s_hsel", {31'b0, s_hsel}, 32'h0);
            checkOutput("t6_noreplay_s_htrans", {30'b0, s_htrans}, 32'h0);
            checkOutput("t6_noreplay_m1_hreadyout", {31'b0, m1_hreadyout}, 32'h1);
            nextCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
